// File: rtl/matrix_dma_pkg.sv
// Shared types for the matrix DMA bridge: FSM states, requester ids and the
// default read data returned for accesses outside the RAM window.
package matrix_dma_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_ACK   = 2'd2,
      ST_ERR   = 2'd3
   } state_t;

   typedef enum logic {
      PORT_CPU = 1'b0,
      PORT_DMA = 1'b1
   } port_t;

   localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: request/grant bit 0 is the CPU, bit 1 the DMA.
// The remembered winner only moves when the grant is actually accepted.
module rr_arb2
   import matrix_dma_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   port_t last_grant;

   // A lone request always wins; a contest goes to whoever did not win last.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == PORT_CPU) ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= PORT_CPU;
      end else if (accept && (|grant)) begin
         last_grant <= grant[1] ? PORT_DMA : PORT_CPU;
      end
   end

endmodule

// File: rtl/matrix_dma_bridge.sv
// Shares one single-port word RAM between the CPU and the matrix core DMA.
// Accesses outside the RAM window are answered with an error and ERR_DATA.
module matrix_dma_bridge
   import matrix_dma_pkg::*;
#(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
   parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [31:0]       dma_addr,
   input  logic [31:0]       dma_wdata,
   output logic [31:0]       dma_rdata,
   output logic              dma_ack,
   output logic              dma_err,

   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [31:0]       cpu_addr,
   input  logic [31:0]       cpu_wdata,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_err,

   output logic              ram_en,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,

   output logic              err_sticky
);

   localparam int unsigned TAG_LSB = ADDR_W + 2;

   state_t      state;
   state_t      state_d;
   port_t       cur_port;
   logic        cur_we;

   logic [1:0]  grant;
   logic        accept;
   port_t       sel_port;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic        in_window;
   logic        addr_unused;

   rr_arb2 u_arb (
      .clk    (clk),
      .reset  (reset),
      .req    ({dma_req, cpu_req}),
      .accept (accept),
      .grant  (grant)
   );

   // Only IDLE listens to requests; everything else walks a fixed path back.
   always_comb begin
      sel_port  = grant[1] ? PORT_DMA : PORT_CPU;
      sel_we    = grant[1] ? dma_we    : cpu_we;
      sel_addr  = grant[1] ? dma_addr  : cpu_addr;
      sel_wdata = grant[1] ? dma_wdata : cpu_wdata;
      in_window = (sel_addr[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
      accept    = (state == ST_IDLE) && (|grant);
      state_d   = state;
      case (state)
         ST_IDLE:  if (accept) state_d = in_window ? ST_ISSUE : ST_ERR;
         ST_ISSUE: state_d = ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   assign addr_unused = ^sel_addr[1:0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_d;
      end
   end

   // The granted port sees its completion while the FSM sits in ACK or ERR.
   always_comb begin
      dma_ack = (state == ST_ACK || state == ST_ERR) && (cur_port == PORT_DMA);
      cpu_ack = (state == ST_ACK || state == ST_ERR) && (cur_port == PORT_CPU);
      dma_err = (state == ST_ERR) && (cur_port == PORT_DMA);
      cpu_err = (state == ST_ERR) && (cur_port == PORT_CPU);
   end

   // RAM strobes are computed from the next state so they line up with ISSUE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         cur_we     <= 1'b0;
         cur_port   <= PORT_CPU;
         dma_rdata  <= '0;
         cpu_rdata  <= '0;
         err_sticky <= 1'b0;
      end else begin
         ram_en <= (state_d == ST_ISSUE);
         ram_we <= (state_d == ST_ISSUE) && sel_we;
         if (accept) begin
            cur_we   <= sel_we;
            cur_port <= sel_port;
            if (in_window) begin
               ram_addr  <= sel_addr[ADDR_W+1:2];
               ram_wdata <= sel_wdata;
            end
         end
         if (state == ST_ACK && !cur_we) begin
            if (cur_port == PORT_DMA) dma_rdata <= ram_rdata;
            else                      cpu_rdata <= ram_rdata;
         end
         // Out-of-window writes are simply dropped; reads get the error pattern.
         if (state == ST_ERR) begin
            err_sticky <= 1'b1;
            if (!cur_we) begin
               if (cur_port == PORT_DMA) dma_rdata <= ERR_DATA;
               else                      cpu_rdata <= ERR_DATA;
            end
         end
      end
   end

endmodule

// File: tb/tb_matrix_dma_bridge.sv
// Directed bench for matrix_dma_bridge with a small synchronous RAM model;
// expected values are hand-computed from the address map and timing.
module tb_matrix_dma_bridge;

   logic        clk;
   logic        reset;
   logic        dma_req, dma_we;
   logic [31:0] dma_addr, dma_wdata, dma_rdata;
   logic        dma_ack, dma_err;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ack, cpu_err;
   logic        ram_en, ram_we;
   logic [11:0] ram_addr;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;
   logic        err_sticky;

   int assertCount = 0;
   int failCount   = 0;
   int dualAck     = 0;

   int          ackCycle;
   logic        ackErr;
   int          ramEnCount;
   logic        c1RamEn, c1RamWe;
   logic [11:0] c1RamAddr;
   logic [31:0] c1RamWdata;

   logic [31:0] mem [0:4095];

   matrix_dma_bridge dut (
      .clk        (clk),
      .reset      (reset),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_wdata  (dma_wdata),
      .dma_rdata  (dma_rdata),
      .dma_ack    (dma_ack),
      .dma_err    (dma_err),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ack    (cpu_ack),
      .cpu_err    (cpu_err),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata),
      .err_sticky (err_sticky)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: read data appears the cycle after a read strobe.
   initial ram_rdata = '0;
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   always @(negedge clk) if (dma_ack && cpu_ack) dualAck++;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // One access on one port; ackCycle counts negedges from the request cycle (0).
   task automatic applyStimulus(input bit isDma, input bit we, input logic [31:0] addr, input logic [31:0] wdata);
      @(posedge clk); #1;
      if (isDma) begin
         dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
      end
      ackCycle = -1; ackErr = 1'b0; ramEnCount = 0;
      c1RamEn = 1'b0; c1RamWe = 1'b0; c1RamAddr = '0; c1RamWdata = '0;
      for (int c = 0; c < 10 && ackCycle < 0; c++) begin
         @(negedge clk);
         if (ram_en) ramEnCount++;
         if (c == 1) begin
            c1RamEn = ram_en; c1RamWe = ram_we; c1RamAddr = ram_addr; c1RamWdata = ram_wdata;
         end
         if (isDma ? dma_ack : cpu_ack) begin
            ackCycle = c;
            ackErr   = isDma ? dma_err : cpu_err;
         end
      end
      dma_req = 1'b0;
      cpu_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic runContest(input string tag);
      int dmaCyc;
      int cpuCyc;
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0001_0040;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0001_0044;
      dmaCyc = -1; cpuCyc = -1;
      for (int c = 0; c < 20 && (dmaCyc < 0 || cpuCyc < 0); c++) begin
         @(negedge clk);
         if (dma_ack) begin dmaCyc = c; dma_req = 1'b0; end
         if (cpu_ack) begin cpuCyc = c; cpu_req = 1'b0; end
      end
      dma_req = 1'b0;
      cpu_req = 1'b0;
      checkOutput({tag, "_dmaAckCycle"}, dmaCyc, 32'd2);
      checkOutput({tag, "_cpuAckCycle"}, cpuCyc, 32'd5);
      @(negedge clk);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int rstAck;
      reset = 1'b0;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      for (int i = 0; i < 4096; i++) mem[i] = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_ramEn",     ram_en,     32'd0);
      checkOutput("rst_ramWe",     ram_we,     32'd0);
      checkOutput("rst_ramAddr",   ram_addr,   32'd0);
      checkOutput("rst_ramWdata",  ram_wdata,  32'd0);
      checkOutput("rst_ackErr",    {dma_ack, dma_err, cpu_ack, cpu_err}, 32'd0);
      checkOutput("rst_dmaRdata",  dma_rdata,  32'd0);
      checkOutput("rst_cpuRdata",  cpu_rdata,  32'd0);
      checkOutput("rst_errSticky", err_sticky, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      $display("[TB] simultaneous requests");
      runContest("contest1");
      runContest("contest2");

      $display("[TB] DMA write then read back");
      applyStimulus(1'b1, 1'b1, 32'h0001_0010, 32'h1234_5678);
      checkOutput("dmaWr_ackCycle", ackCycle,   32'd2);
      checkOutput("dmaWr_err",      ackErr,     32'd0);
      checkOutput("dmaWr_c1RamEn",  c1RamEn,    32'd1);
      checkOutput("dmaWr_c1RamWe",  c1RamWe,    32'd1);
      checkOutput("dmaWr_c1Addr",   c1RamAddr,  32'd4);
      checkOutput("dmaWr_c1Wdata",  c1RamWdata, 32'h1234_5678);
      checkOutput("dmaWr_mem4",     mem[4],     32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 32'h0001_0010, 32'h0);
      checkOutput("dmaRd_ackCycle", ackCycle,   32'd2);
      checkOutput("dmaRd_c1RamWe",  c1RamWe,    32'd0);
      checkOutput("dmaRd_rdata",    dma_rdata,  32'h1234_5678);

      $display("[TB] CPU traffic between DMA reads");
      applyStimulus(1'b0, 1'b1, 32'h0001_0020, 32'hCAFE_F00D);
      checkOutput("cpuWr_ackCycle",  ackCycle,  32'd2);
      checkOutput("cpuWr_dmaRdata",  dma_rdata, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0001_0020, 32'h0);
      checkOutput("cpuRd_rdata",     cpu_rdata, 32'hCAFE_F00D);
      checkOutput("cpuRd_dmaRdata",  dma_rdata, 32'h1234_5678);
      applyStimulus(1'b1, 1'b0, 32'h0001_0020, 32'h0);
      checkOutput("dmaRd2_rdata",    dma_rdata, 32'hCAFE_F00D);
      checkOutput("dmaRd2_cpuRdata", cpu_rdata, 32'hCAFE_F00D);
      applyStimulus(1'b1, 1'b0, 32'h0001_0013, 32'h0);
      checkOutput("lowBits_c1Addr",  c1RamAddr, 32'd4);
      checkOutput("lowBits_rdata",   dma_rdata, 32'h1234_5678);

      $display("[TB] window boundaries");
      applyStimulus(1'b1, 1'b1, 32'h0001_3FFC, 32'hA5A5_0001);
      checkOutput("lastWr_c1Addr",   c1RamAddr, 32'h0000_0FFF);
      checkOutput("lastWr_err",      ackErr,    32'd0);
      applyStimulus(1'b1, 1'b0, 32'h0001_3FFC, 32'h0);
      checkOutput("lastRd_rdata",    dma_rdata, 32'hA5A5_0001);
      checkOutput("preErr_sticky",   err_sticky, 32'd0);

      applyStimulus(1'b0, 1'b0, 32'h0000_0100, 32'h0);
      checkOutput("cpuErr_ackCycle", ackCycle,   32'd1);
      checkOutput("cpuErr_err",      ackErr,     32'd1);
      checkOutput("cpuErr_ramEn",    ramEnCount, 32'd0);
      checkOutput("cpuErr_rdata",    cpu_rdata,  32'hDEAD_BEEF);
      checkOutput("cpuErr_sticky",   err_sticky, 32'd1);
      checkOutput("cpuErr_dmaRdata", dma_rdata,  32'hA5A5_0001);

      applyStimulus(1'b1, 1'b0, 32'h0001_4000, 32'h0);
      checkOutput("dmaErr_ackCycle", ackCycle,   32'd1);
      checkOutput("dmaErr_err",      ackErr,     32'd1);
      checkOutput("dmaErr_ramEn",    ramEnCount, 32'd0);
      checkOutput("dmaErr_rdata",    dma_rdata,  32'hDEAD_BEEF);

      applyStimulus(1'b1, 1'b1, 32'h2000_0000, 32'h5555_AAAA);
      checkOutput("dmaErrWr_err",    ackErr,     32'd1);
      checkOutput("dmaErrWr_ramEn",  ramEnCount, 32'd0);
      checkOutput("dmaErrWr_rdata",  dma_rdata,  32'hDEAD_BEEF);
      checkOutput("dmaErrWr_sticky", err_sticky, 32'd1);

      $display("[TB] reset during ISSUE");
      @(posedge clk); #1;
      dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h0001_0010;
      @(negedge clk);
      @(negedge clk);
      checkOutput("midRst_issueRamEn", ram_en, 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midRst_ramEn",   ram_en,     32'd0);
      checkOutput("midRst_ramAddr", ram_addr,   32'd0);
      checkOutput("midRst_acks",    {dma_ack, dma_err, cpu_ack, cpu_err}, 32'd0);
      checkOutput("midRst_rdata",   dma_rdata,  32'd0);
      checkOutput("midRst_sticky",  err_sticky, 32'd0);
      rstAck = 0;
      repeat (2) begin
         @(negedge clk);
         if (dma_ack || cpu_ack) rstAck++;
      end
      checkOutput("midRst_noAck", rstAck, 32'd0);
      reset = 1'b1;
      ackCycle = -1;
      for (int c = 1; c < 10 && ackCycle < 0; c++) begin
         @(negedge clk);
         if (dma_ack) ackCycle = c;
      end
      dma_req = 1'b0;
      checkOutput("afterRst_ackCycle", ackCycle, 32'd2);
      @(negedge clk);
      checkOutput("afterRst_rdata", dma_rdata, 32'h1234_5678);

      checkOutput("noDualAck", dualAck, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/matrix_dma_bridge.md
MATRIX_DMA_BRIDGE -- requirements
Module: matrix_dma_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, RAM word-address width (4096 words, 16 KiB).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0001_0000, byte base of the RAM window; aligned to 4*2^ADDR_W.
REQ-003 SHALL have parameter ERR_DATA, default 32'hDEAD_BEEF, read data returned for out-of-window accesses.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-006 dma_req  input  1  matrix core DMA request, level, held until dma_ack.
REQ-007 dma_we  input  1  DMA write (1) / read (0), stable while dma_req.
REQ-008 dma_addr  input  32  DMA byte address, stable while dma_req.
REQ-009 dma_wdata  input  32  DMA write data (core dma_data_o).
REQ-010 dma_rdata  output  32  DMA read data (core dma_data_i).
REQ-011 dma_ack  output  1  one-cycle completion pulse to core.
REQ-012 dma_err  output  1  pulses with dma_ack when the access was out of window.
REQ-013 cpu_req, cpu_we, cpu_addr[31:0], cpu_wdata[31:0]  inputs; cpu_rdata[31:0], cpu_ack, cpu_err  outputs; same rules as the DMA port.
REQ-014 ram_en, ram_we  output  1  RAM strobe / write enable.
REQ-015 ram_addr  output  ADDR_W  RAM word address.
REQ-016 ram_wdata  output  32 / ram_rdata  input  32  RAM data; ram_rdata valid the cycle after ram_en with ram_we=0.
REQ-017 err_sticky  output  1  set on any out-of-window access, cleared only by reset.

Function
REQ-018 FSM states IDLE, ISSUE, ACK, ERR; all RAM-side outputs SHALL be registered.
REQ-019 IDLE: if any req, the arbiter SHALL pick a port, latch its we/addr/wdata and port id, and go to ISSUE (in window) or ERR (out of window); no req -> stay IDLE.
REQ-020 Arbitration: single req wins; both req -> the port not granted last wins; the last-grant flag resets to CPU, so the first simultaneous contest goes to DMA.
REQ-021 ISSUE: ram_en=1, ram_we=latched we, ram_addr=addr[ADDR_W+1:2], ram_wdata=latched wdata; go to ACK.
REQ-022 ACK: the granted port's ack=1 for exactly one cycle; for reads its rdata register SHALL load ram_rdata; go to IDLE.
REQ-023 ERR: no RAM strobe; the granted port's ack=1 and err=1; a read SHALL load ERR_DATA, a write SHALL be dropped; err_sticky set; go to IDLE.
REQ-024 Latency: req seen in IDLE at cycle 0 -> ack in cycle 2 (in window) or cycle 1 (ERR).
REQ-025 The FSM SHALL ignore req in ISSUE, ACK and ERR; a requester that still holds req in the IDLE cycle after ack starts a new access.
REQ-026 Window test: addr[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]; addr[1:0] ignored (word access only).
REQ-027 rdata of each port SHALL hold its last loaded value until that port's next read completes; a write or the other port's access SHALL not change it.
REQ-028 ram_en SHALL never be high outside ISSUE; at most one ack per cycle across both ports.

Reset
REQ-029 While reset=0: state=IDLE, ram_en=ram_we=0, ram_addr=0, ram_wdata=0, both ack/err=0, both rdata=0, err_sticky=0, last-grant=CPU.
REQ-030 Reset asserted mid-access SHALL abort immediately with no ack; after release the requester must reissue.

Structure
REQ-031 Package matrix_dma_pkg SHALL hold the FSM state enum, port-id enum (PORT_CPU, PORT_DMA) and the ERR_DATA default.
REQ-032 Arbitration SHALL be a sub-module rr_arb2 (2 requests, grant one-hot, update on accept) instantiated once.

Verification
REQ-033 DMA write 32'h1234_5678 to 32'h0001_0010 -> cycle 1 ram_en=1, ram_we=1, ram_addr=4; dma_ack cycle 2; later DMA read of same address returns 32'h1234_5678.
REQ-034 cpu_req and dma_req rise together, both held -> DMA acked first, then CPU; repeat -> grant alternation DMA, CPU, DMA, CPU.
REQ-035 CPU read of 32'h0000_0100 -> cpu_ack=cpu_err=1 in cycle 1, cpu_rdata=32'hDEAD_BEEF, no ram_en, err_sticky=1 until reset.
REQ-036 DMA read of 32'h0001_3FFC (last word) -> ram_addr=12'hFFF; address 32'h0001_4000 -> ERR path.
REQ-037 Reset pulled low in ISSUE -> no ack, all outputs zero; after release the same request completes normally.
REQ-038 CPU write completes between two DMA reads -> dma_rdata unchanged by the CPU access.
